bsg_manycore_pkt_encode_buffered: RTL
=====================================

// Module: bsg_manycore_pkt_encode_buffered
// PURPOSE
//  Registered, credit-tracked successor of the combinational manycore packet encoder.
//  - Accepts core memory requests over valid/ready and decodes remote addresses.
//  - Pushes remote stores and lock ops into an output FIFO feeding the mesh router.
//  - Counts outstanding-store credits and runs a lock-acquire state machine.
//  - Answers credit/lock status loads locally, one cycle later.
// PARAMETERS
//  x_cord_width_p     "inv"  mesh X coordinate width
//  y_cord_width_p     "inv"  mesh Y coordinate width
//  data_width_p       "inv"  data width; multiple of 8
//  addr_width_p       "inv"  packet address width
//  fifo_els_p         2      output FIFO depth; >=2
//  max_out_credits_p  16     maximum outstanding packets; >=1
//  Derived:
//   in_addr_lp = 1+y_cord_width_p+x_cord_width_p+addr_width_p
//   cw_lp      = $clog2(max_out_credits_p+1)
//   pkt_lp     = addr_width_p+2+data_width_p/8+data_width_p+2*(x_cord_width_p+y_cord_width_p)
// PORTS
//  clk_i              in   1               clock
//  reset_i            in   1               asynchronous active-high reset
//  v_i                in   1               request valid
//  ready_o            out  1               request accepted when v_i&ready_o
//  addr_i             in   in_addr_lp      {remote, y_cord, x_cord, addr}, MSB->LSB
//  data_i             in   data_width_p    store data
//  mask_i             in   data_width_p/8  byte mask -> op_ex
//  we_i               in   1               1=store, 0=load
//  my_x_i             in   x_cord_width_p  own X coordinate
//  my_y_i             in   y_cord_width_p  own Y coordinate
//  v_o                out  1               packet valid (FIFO non-empty)
//  data_o             out  pkt_lp          {addr, op, op_ex, data, from_y, from_x, y_cord, x_cord}
//  ready_i            in   1               router pops on v_o&ready_i
//  credit_v_i         in   1               one outstanding packet retired
//  lock_grant_i       in   1               remote lock granted
//  out_credits_o      out  cw_lp           available credits
//  resp_v_o           out  1               status-load response valid
//  resp_data_o        out  data_width_p    status-load response data
// BEHAVIOUR
//  Reset values:
//   - FIFO empty, so v_o=0.
//   - out_credits_o = max_out_credits_p.
//   - Lock state = IDLE.
//   - resp_v_o = 0, resp_data_o = 0.
//   - Reset mid-operation discards all queued packets.
//  Classification of an accepted request (k = addr[3:2]):
//   - remote=0: consumed with no effect; ready_o=1.
//   - Remote store: pkt op = addr[addr_width_p-1] ? 2'b10 : 2'b01.
//   - Remote load k=3: lock request, op 2'b11.
//   - Remote load k=0: lock release, op 2'b00.
//   - Remote load k=1: status, resp_data_o = zero-extended out_credits_o.
//   - Remote load k=2: status, resp_data_o = {0, state[1:0]} (IDLE=0, WAIT=1, LOCKED=2).
//  Packet fields:
//   - pkt.addr = {1'b0, addr[addr_width_p-2:0]}.
//   - op_ex = mask_i; from_x/from_y = my_x_i/my_y_i.
//   - x_cord/y_cord taken from addr_i.
//  ready_o for a packet-producing request:
//   - Requires FIFO not full and out_credits_o != 0.
//   - A lock request additionally requires state==IDLE.
//   - No same-cycle bypass: a full FIFO stalls even when popping.
//  Latency:
//   - Packet appears on v_o/data_o the cycle after acceptance.
//   - resp_v_o is a one-cycle pulse the cycle after a status load is accepted.
//   - Status data is sampled on the accept cycle.
//  FIFO: in-order, push and pop in the same cycle allowed when not full.
//  Credits:
//   - -1 per packet pushed; +1 per credit_v_i; both in one cycle = unchanged.
//   - credit_v_i at max is ignored (saturate) and flagged by a simulation $error.
//  Lock FSM:
//   - IDLE -(lock req accepted)-> WAIT -(lock_grant_i)-> LOCKED -(release accepted)-> IDLE.
//   - lock_grant_i outside WAIT is ignored.
//   - A release in IDLE/WAIT still sends its packet and forces IDLE.
// TESTING
//  1. Reset, then remote store addr field 0x004 (top bit 0) -> next cycle v_o=1, op=01,
//     op_ex=mask, from=my; out_credits_o=15 (max 16).
//  2. Store with addr top bit set -> op=10, pkt.addr top bit cleared.
//  3. ready_i=0, three stores with fifo_els_p=2 -> third stalls (ready_o=0);
//     one pop -> third accepted next cycle.
//  4. 16 stores with no credit_v_i -> 17th stalls; credit_v_i pulse -> accepted;
//     simultaneous push+credit leaves count unchanged.
//  5. Lock req -> op=11, k=2 load returns 1; second lock req stalls;
//     lock_grant_i -> k=2 returns 2; release -> op=00, state 0.
//  6. Assert reset_i mid-traffic with FIFO holding 2 -> v_o=0 immediately,
//     credits=16, state IDLE.

Source files
------------

// File: rtl/bsg_manycore_pkt_encode_buffered.sv
// Registered manycore packet encoder with an output FIFO, outstanding-store
// credit counter and a lock-acquire state machine.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   v_i/ready_o             core request handshake (addr_i, data_i, mask_i, we_i)
//   my_x_i/my_y_i           own mesh coordinates, stamped into packets
//   v_o/data_o/ready_i      packet stream toward the mesh router
//   credit_v_i              one outstanding packet retired
//   lock_grant_i            remote lock granted
//   out_credits_o           available credits
//   resp_v_o/resp_data_o    status-load response, one cycle after accept
module bsg_manycore_pkt_encode_buffered #(
  parameter int unsigned x_cord_width_p    = 4,
  parameter int unsigned y_cord_width_p    = 4,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned addr_width_p      = 12,
  parameter int unsigned fifo_els_p        = 2,
  parameter int unsigned max_out_credits_p = 16,
  localparam int unsigned in_addr_lp = 1 + y_cord_width_p + x_cord_width_p + addr_width_p,
  localparam int unsigned cw_lp      = $clog2(max_out_credits_p + 1),
  localparam int unsigned mask_w_lp  = data_width_p / 8,
  localparam int unsigned pkt_lp     = addr_width_p + 2 + mask_w_lp + data_width_p
                                       + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [in_addr_lp-1:0]     addr_i,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [mask_w_lp-1:0]      mask_i,
  input  logic                      we_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  output logic                      v_o,
  output logic [pkt_lp-1:0]         data_o,
  input  logic                      ready_i,
  input  logic                      credit_v_i,
  input  logic                      lock_grant_i,
  output logic [cw_lp-1:0]          out_credits_o,
  output logic                      resp_v_o,
  output logic [data_width_p-1:0]   resp_data_o
);

  localparam int unsigned ptr_w_lp = $clog2(fifo_els_p);
  localparam int unsigned cnt_w_lp = $clog2(fifo_els_p + 1);

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_wait   = 2'd1,
    e_locked = 2'd2
  } lock_state_e;

  lock_state_e state_r, state_n;

  // Request address decode
  logic                      remote;
  logic [y_cord_width_p-1:0] dst_y;
  logic [x_cord_width_p-1:0] dst_x;
  logic [addr_width_p-1:0]   dst_addr;
  logic [1:0]                k;

  assign remote   = addr_i[in_addr_lp-1];
  assign dst_y    = addr_i[addr_width_p+x_cord_width_p +: y_cord_width_p];
  assign dst_x    = addr_i[addr_width_p +: x_cord_width_p];
  assign dst_addr = addr_i[addr_width_p-1:0];
  assign k        = dst_addr[3:2];

  logic is_store, is_lock, is_release, is_status, pkt_req;
  assign is_store   = remote && we_i;
  assign is_lock    = remote && !we_i && (k == 2'd3);
  assign is_release = remote && !we_i && (k == 2'd0);
  assign is_status  = remote && !we_i && ((k == 2'd1) || (k == 2'd2));
  assign pkt_req    = is_store || is_lock || is_release;

  // Packet opcode
  logic [1:0] pkt_op;
  always_comb begin
    pkt_op = 2'b00;
    if (is_store)     pkt_op = dst_addr[addr_width_p-1] ? 2'b10 : 2'b01;
    else if (is_lock) pkt_op = 2'b11;
  end

  logic [pkt_lp-1:0] pkt_word;
  assign pkt_word = {1'b0, dst_addr[addr_width_p-2:0], pkt_op, mask_i, data_i,
                     my_y_i, my_x_i, dst_y, dst_x};

  // Handshake; a full FIFO stalls even when it is being popped
  logic [cnt_w_lp-1:0] count_r;
  logic [cw_lp-1:0]    credits_r;
  logic fifo_full, can_push, accept, push, pop, credit_ok;

  assign fifo_full = (count_r == cnt_w_lp'(fifo_els_p));
  assign can_push  = !fifo_full && (credits_r != '0);
  assign ready_o   = !remote || is_status || (can_push && (!is_lock || (state_r == e_idle)));
  assign accept    = v_i && ready_o;
  assign push      = accept && pkt_req;
  assign v_o       = (count_r != '0);
  assign pop       = v_o && ready_i;
  assign credit_ok = credit_v_i && (credits_r != cw_lp'(max_out_credits_p));

  // Output FIFO: circular buffer
  logic [pkt_lp-1:0]   mem_r [fifo_els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= pkt_word;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign data_o = mem_r[rd_ptr_r];

  // Credit counter; a return at max is dropped
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r <= cw_lp'(max_out_credits_p);
    end else begin
      case ({push, credit_ok})
        2'b10:   credits_r <= credits_r - cw_lp'(1);
        2'b01:   credits_r <= credits_r + cw_lp'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  assign out_credits_o = credits_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(credit_v_i && (credits_r == cw_lp'(max_out_credits_p))))
        else $error("credit returned while credit counter is at maximum");
  end

  // Lock FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Lock FSM: next state; an accepted release always returns to idle
  always_comb begin
    state_n = state_r;
    if (accept && is_release) begin
      state_n = e_idle;
    end else begin
      case (state_r)
        e_idle:  if (accept && is_lock) state_n = e_wait;
        e_wait:  if (lock_grant_i)      state_n = e_locked;
        default: state_n = state_r;
      endcase
    end
  end

  // Status-load response, sampled on the accept cycle
  logic [1:0] state_bits;
  assign state_bits = state_r;

  logic                    resp_v_r;
  logic [data_width_p-1:0] resp_data_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_v_r    <= 1'b0;
      resp_data_r <= '0;
    end else begin
      resp_v_r <= accept && is_status;
      if (accept && is_status)
        resp_data_r <= (k == 2'd1) ? data_width_p'(credits_r) : data_width_p'(state_bits);
    end
  end

  assign resp_v_o    = resp_v_r;
  assign resp_data_o = resp_data_r;

endmodule
